disp2421_decade_driver: RTL and testbench

Downstream consumer of the 2421-code decade counter. Samples the counter's 4-bit 2421 state and converts it to 8421 BCD (ones digit). Counts decade wrap-arounds into a BCD tens digit and flags illegal 2421 codes. Drives a 2-digit time-multiplexed 7-segment display on the practice board.

---
 rtl/disp2421_decade_driver.sv | 88 ++++++++
 tb/tb_disp2421_decade_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/disp2421_decade_driver.sv
// disp2421_decade_driver: 2421-to-BCD ones digit, wrap-counted tens digit, sticky illegal-code flag, 2-digit muxed 7-seg drive; DISP2421_ZERO_BLANK_EN blanks a zero tens digit
module disp2421_decade_driver #(
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] code_in,
    input  logic       code_valid,
    output logic [3:0] ones_bcd,
    output logic [3:0] tens_bcd,
    output logic       wrap_pulse,
    output logic       code_err,
    output logic [6:0] seg,
    output logic [1:0] an
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic          sel;
    logic          legal;
    logic          is_wrap;
    logic [3:0]    dec;
    logic [6:0]    seg_raw;
    logic [1:0]    an_raw;

    function automatic logic [6:0] pattern(input logic [3:0] d);
        case (d)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h00;
        endcase
    endfunction

    // decode the 2421 code and pick the active-high image of the selected digit
    always_comb begin
        legal   = code_in <= 4'd4 || code_in >= 4'd11;
        dec     = code_in <= 4'd4 ? code_in : code_in - 4'd6;
        is_wrap = legal && ones_bcd == 4'd9 && dec == 4'd0;
        an_raw  = sel ? 2'b10 : 2'b01;
`ifdef DISP2421_ZERO_BLANK_EN
        seg_raw = sel ? (tens_bcd == 4'd0 ? 7'h00 : pattern(tens_bcd)) : pattern(ones_bcd);
`else
        seg_raw = sel ? pattern(tens_bcd) : pattern(ones_bcd);
`endif
    end

    // digit registers: legal samples load ones, a 9->0 step bumps tens; illegal samples only set the sticky flag
    always_ff @(posedge clk) begin
        if (reset) begin
            ones_bcd   <= 4'd0;
            tens_bcd   <= 4'd0;
            wrap_pulse <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            wrap_pulse <= code_valid && is_wrap;
            if (code_valid && legal) ones_bcd <= dec;
            if (code_valid && is_wrap) tens_bcd <= tens_bcd == 4'd9 ? 4'd0 : tens_bcd + 4'd1;
            if (code_valid && !legal) code_err <= 1'b1;
        end
    end

    // refresh counter: each digit stays selected for REFRESH_DIV cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            sel <= 1'b0;
        end else begin
            cnt <= cnt == LAST ? '0 : cnt + 1'b1;
            sel <= cnt == LAST ? ~sel : sel;
        end
    end

    // registered, polarity-adjusted display drive; reset shows a 0 on the ones digit
    always_ff @(posedge clk) begin
        seg <= {7{SEG_ACTIVE_LOW}} ^ (reset ? 7'h3F : seg_raw);
        an  <= {2{SEG_ACTIVE_LOW}} ^ (reset ? 2'b01 : an_raw);
    end
endmodule

// File: tb/tb_disp2421_decade_driver.sv
// tb_disp2421_decade_driver: vector table, corner sequences and randomized run against a behavioural model
module tb_disp2421_decade_driver;
    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] code_in = 4'd0;
    logic       code_valid = 1'b0;
    logic [3:0] ones_bcd, tens_bcd, ones2, tens2;
    logic       wrap_pulse, code_err, wrap2, err2;
    logic [6:0] seg_lo, seg_hi;
    logic [1:0] an_lo, an_hi;

    always #5 clk = ~clk;

    disp2421_decade_driver #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .ones_bcd(ones_bcd), .tens_bcd(tens_bcd), .wrap_pulse(wrap_pulse),
        .code_err(code_err), .seg(seg_lo), .an(an_lo)
    );

    disp2421_decade_driver #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .ones_bcd(ones2), .tens_bcd(tens2), .wrap_pulse(wrap2),
        .code_err(err2), .seg(seg_hi), .an(an_hi)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural reference: decimal digits, a wrap count and elapsed-cycle display timing
    int          m_ones, m_tens, m_wrap, m_err, t;
    logic [6:0]  e_seg;
    logic [1:0]  e_an;
    int          pat [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    typedef struct {
        logic       v;
        logic [3:0] c;
        int         ones;
        int         tens;
        int         wrap;
        int         err;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic model_reset();
        m_ones = 0; m_tens = 0; m_wrap = 0; m_err = 0; t = 0;
        e_seg = 7'h3F; e_an = 2'b01;
    endtask

    task automatic model_step(input logic v, input logic [3:0] c);
        int sel, d, dv;
        sel = (t / RD) % 2;
        d = sel ? m_tens : m_ones;
        e_seg = 7'(pat[d]);
`ifdef DISP2421_ZERO_BLANK_EN
        if (sel == 1 && m_tens == 0) e_seg = 7'h00;
`endif
        e_an = sel ? 2'b10 : 2'b01;
        m_wrap = 0;
        if (v) begin
            if (c <= 4 || c >= 11) begin
                dv = c <= 4 ? int'(c) : int'(c) - 6;
                if (m_ones == 9 && dv == 0) begin
                    m_wrap = 1;
                    m_tens = (m_tens + 1) % 10;
                end
                m_ones = dv;
            end else m_err = 1;
        end
        t++;
    endtask

    task automatic check_all();
        logic [6:0] x_seg;
        logic [1:0] x_an;
        x_seg = ~e_seg;
        x_an = ~e_an;
        chk("ones_bcd", ones_bcd, m_ones);
        chk("tens_bcd", tens_bcd, m_tens);
        chk("wrap_pulse", wrap_pulse, m_wrap);
        chk("code_err", code_err, m_err);
        chk("seg_lo", seg_lo, x_seg);
        chk("an_lo", an_lo, x_an);
        chk("ones_hi", ones2, m_ones);
        chk("seg_hi", seg_hi, e_seg);
        chk("an_hi", an_hi, e_an);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        code_valid = 1'b1;
        code_in = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        code_valid = 1'b0;
        model_reset();
        check_all();
    endtask

    task automatic cyc(input logic v, input logic [3:0] c);
        code_valid = v;
        code_in = c;
        @(posedge clk);
        model_step(v, c);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        vec_t vt [17];
        int   wraps, c07, c4f, idx;
        logic [3:0] seq [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        vt = '{
            '{1'b1, 4'd0,  0, 0, 0, 0}, '{1'b1, 4'd1,  1, 0, 0, 0},
            '{1'b1, 4'd2,  2, 0, 0, 0}, '{1'b1, 4'd3,  3, 0, 0, 0},
            '{1'b1, 4'd4,  4, 0, 0, 0}, '{1'b1, 4'd11, 5, 0, 0, 0},
            '{1'b1, 4'd12, 6, 0, 0, 0}, '{1'b1, 4'd13, 7, 0, 0, 0},
            '{1'b1, 4'd14, 8, 0, 0, 0}, '{1'b1, 4'd15, 9, 0, 0, 0},
            '{1'b1, 4'd0,  0, 1, 1, 0}, '{1'b1, 4'd0,  0, 1, 0, 0},
            '{1'b0, 4'd15, 0, 1, 0, 0}, '{1'b1, 4'd7,  0, 1, 0, 1},
            '{1'b1, 4'd12, 6, 1, 0, 1}, '{1'b1, 4'd15, 9, 1, 0, 1},
            '{1'b1, 4'd0,  0, 2, 1, 1}
        };

        do_reset();
        chk("reset_seg", seg_lo, 7'h40);
        chk("reset_an", an_lo, 2'b10);

        foreach (vt[i]) begin
            cyc(vt[i].v, vt[i].c);
            chk("vec_ones", ones_bcd, vt[i].ones);
            chk("vec_tens", tens_bcd, vt[i].tens);
            chk("vec_wrap", wrap_pulse, vt[i].wrap);
            chk("vec_err", code_err, vt[i].err);
        end

        do_reset();
        chk("err_cleared", code_err, 0);
        cyc(1'b1, 4'd15);
        wraps = 0;
        repeat (3) begin
            cyc(1'b1, 4'd0);
            wraps += int'(wrap_pulse);
        end
        chk("held_wrap_count", wraps, 1);

        do_reset();
        wraps = 0;
        for (int d = 0; d < 100; d++)
            for (int k = 0; k < 10; k++) begin
                cyc(1'b1, seq[k]);
                wraps += int'(wrap_pulse);
            end
        cyc(1'b1, 4'd0);
        wraps += int'(wrap_pulse);
        chk("decade_wraps", wraps, 100);
        chk("tens_rollover", tens_bcd, 0);

        do_reset();
        repeat (3) begin
            cyc(1'b1, 4'd15);
            cyc(1'b1, 4'd0);
        end
        cyc(1'b1, 4'd13);
        chk("disp_ones", ones_bcd, 7);
        chk("disp_tens", tens_bcd, 3);
        c07 = 0;
        c4f = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 4'd0);
            if (seg_hi == 7'h07 && an_hi == 2'b01) c07++;
            if (seg_hi == 7'h4F && an_hi == 2'b10) c4f++;
        end
        chk("ones_slot_cycles", c07, 8);
        chk("tens_slot_cycles", c4f, 8);

        do_reset();
        cyc(1'b1, 4'd13);
        repeat (10) cyc(1'b0, 4'd0);

        do_reset();
        idx = 0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                do_reset();
                idx = 0;
            end
            if ($urandom_range(0, 9) < 8) begin
                cyc($urandom_range(0, 3) != 0, seq[idx]);
                idx = (idx + 1) % 10;
            end else cyc(1'b1, 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
